// File: rtl/qdac_pkg.sv
// Shared types and default sizing for the QDAC SAR readback controller.
// Holds the FSM state encoding and the cycle-count defaults that both RTL and bench use.
package qdac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DUMP,
    SAMPLE,
    SETTLE,
    COMPARE,
    DONE
  } sar_state_e;

  localparam int QDAC_N_BITS          = 5;
  localparam int QDAC_CMP_SYNC_STAGES = 2;
  localparam int QDAC_SAMPLE_CYCLES   = 8;
  localparam int QDAC_SETTLE_CYCLES   = 4;

  // Wide enough for the longest in-state count, including the synchronizer extension.
  function automatic int qdac_cnt_width(input int sample_cycles, input int settle_cycles);
    int longest;
    longest = (sample_cycles > settle_cycles + QDAC_CMP_SYNC_STAGES) ?
              sample_cycles : settle_cycles + QDAC_CMP_SYNC_STAGES;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/qdac_cmp_sync.sv
// Multi-flop synchronizer for the Amplifier9T comparator output into the clk domain.
// Latency QDAC_CMP_SYNC_STAGES cycles; no backpressure.
module qdac_cmp_sync
  import qdac_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [QDAC_CMP_SYNC_STAGES-1:0] sync_q;
  logic [QDAC_CMP_SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[QDAC_CMP_SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[QDAC_CMP_SYNC_STAGES-1];

endmodule

// File: rtl/qdac_sar_controller.sv
// SAR sequencer reading an analog input back through the QDAC array; start->done 36 cycles at defaults
// (46 with QDAC_SAR_CMP_SYNC_EN, which adds a comparator synchronizer). No backpressure: start ignored while busy.
module qdac_sar_controller
  import qdac_pkg::*;
#(
  parameter int N_BITS        = QDAC_N_BITS,
  parameter int SAMPLE_CYCLES = QDAC_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = QDAC_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cmp_in,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result,
  output logic              tg_dump,
  output logic              tg_sample,
  output logic [N_BITS-1:0] tg_ctrl
);

  localparam int CNT_W = qdac_cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  logic cmp_val;

`ifdef QDAC_SAR_CMP_SYNC_EN
  localparam int SETTLE_TOTAL = SETTLE_CYCLES + QDAC_CMP_SYNC_STAGES;

  qdac_cmp_sync u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_val)
  );
`else
  localparam int SETTLE_TOTAL = SETTLE_CYCLES;

  assign cmp_val = cmp_in;
`endif

  sar_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_BITS-1:0] tg_ctrl_q, tg_ctrl_d;
  logic [N_BITS-1:0] result_q, result_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tg_ctrl_d = tg_ctrl_q;
    result_d  = result_q;

    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      cnt_d     = '0;
      tg_ctrl_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = DUMP;
          end
        end
        DUMP: begin
          state_d   = SAMPLE;
          cnt_d     = '0;
          tg_ctrl_d = '0;
        end
        SAMPLE: begin
          if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state_d          = SETTLE;
            cnt_d            = '0;
            idx_d            = IDX_W'(N_BITS - 1);
            tg_ctrl_d        = '0;
            tg_ctrl_d[N_BITS-1] = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_TOTAL - 1)) begin
            state_d = COMPARE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        COMPARE: begin
          // DAC node above the held input means this trial bit overshot.
          if (cmp_val) begin
            tg_ctrl_d[idx_q] = 1'b0;
          end
          if (idx_q == '0) begin
            state_d  = DONE;
            result_d = tg_ctrl_d;
          end else begin
            state_d          = SETTLE;
            idx_d            = idx_q - IDX_W'(1);
            tg_ctrl_d[idx_d] = 1'b1;
          end
        end
        DONE: begin
          state_d   = IDLE;
          tg_ctrl_d = '0;
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          tg_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      tg_ctrl_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tg_ctrl_q <= tg_ctrl_d;
      result_q  <= result_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign tg_dump   = (state_q == DUMP);
  assign tg_sample = (state_q == SAMPLE);
  assign tg_ctrl   = tg_ctrl_q;
  assign result    = result_q;

endmodule

// File: tb/tb_qdac_sar_controller.sv
// Directed bench for qdac_sar_controller: vector table of conversions plus abort/reset/start-overlap sequences.
module tb_qdac_sar_controller;

  localparam int MODE_MODEL  = 0;
  localparam int MODE_STUCK0 = 1;
  localparam int MODE_STUCK1 = 2;

`ifdef QDAC_SAR_CMP_SYNC_EN
  localparam int EXP_LAT = 46;
`else
  localparam int EXP_LAT = 36;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       cmp_in;
  logic       busy;
  logic       done;
  logic [4:0] result;
  logic       tg_dump;
  logic       tg_sample;
  logic [4:0] tg_ctrl;

  int         cmp_mode;
  logic [4:0] code;
  int         checks   = 0;
  int         errors   = 0;
  int         done_cnt = 0;

  typedef struct {
    int         mode;
    logic [4:0] code;
    logic [4:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  qdac_sar_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cmp_in    (cmp_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .tg_dump   (tg_dump),
    .tg_sample (tg_sample),
    .tg_ctrl   (tg_ctrl)
  );

  always #5 clk = ~clk;

  // Comparator model: DAC node is above the input when the trial code exceeds it.
  always_comb begin
    cmp_in = 1'b0;
    case (cmp_mode)
      MODE_MODEL:  cmp_in = (tg_ctrl > code);
      MODE_STUCK1: cmp_in = 1'b1;
      default:     cmp_in = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst) begin
      check("tg_exclusive",
            32'(((tg_dump && tg_sample) || ((tg_dump || tg_sample) && (tg_ctrl != 5'b0))) ? 1 : 0),
            32'd0);
    end
  end

  // Starts a conversion; lat counts the start cycle as 1 and returns the cycle on which done is seen.
  task automatic run_conv(output int lat);
    @(negedge clk);
    start = 1'b1;
    lat   = 1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         d0;
    logic [4:0] prev_res;

    vecs[0] = '{MODE_MODEL,  5'b10110, 5'b10110};
    vecs[1] = '{MODE_STUCK1, 5'b00000, 5'b00000};
    vecs[2] = '{MODE_MODEL,  5'b11111, 5'b11111};
    vecs[3] = '{MODE_MODEL,  5'b00000, 5'b00000};
    vecs[4] = '{MODE_STUCK0, 5'b00000, 5'b11111};
    vecs[5] = '{MODE_MODEL,  5'b01001, 5'b01001};

    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    cmp_mode = MODE_MODEL;
    code     = 5'b10110;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_tg",     32'({tg_dump, tg_sample, tg_ctrl}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cmp_mode = vecs[i].mode;
      code     = vecs[i].code;
      run_conv(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(EXP_LAT));
      check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d_busy_on_done", i), 32'(busy), 32'd1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_tg_ctrl_after", i), 32'(tg_ctrl), 32'd0);
      check($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_done_after", i), 32'(done), 32'd0);
    end

    // Abort during the third SETTLE cycle of bit 3.
    cmp_mode = MODE_MODEL;
    code     = 5'b10110;
    prev_res = result;
    d0       = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("abort_pre_tg_ctrl", 32'(tg_ctrl), 32'(5'b11000));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tg", 32'({tg_dump, tg_sample, tg_ctrl}), 32'd0);
    check("abort_result", 32'(result), 32'(prev_res));
    repeat (50) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // start while idle together with abort: no conversion.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);

    // start pulsed mid-conversion and on the DONE cycle is ignored.
    code = 5'b01101;
    d0   = done_cnt;
    @(negedge clk);
    check("busy_before_start", 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("dump_cycle", 32'({tg_dump, tg_sample, tg_ctrl}), 32'(7'b1000000));
    lat = 2;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 12);
    end
    check("overlap_latency", 32'(lat), 32'(EXP_LAT));
    check("overlap_result", 32'(result), 32'(5'b01101));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_on_done_ignored", 32'(busy), 32'd0);
    repeat (60) @(posedge clk);
    #1;
    check("one_done_per_start", 32'(done_cnt - d0), 32'd1);
    check("idle_after_overlap", 32'(busy), 32'd0);

    // Reset in the middle of SAMPLE.
    code = 5'b10110;
    d0   = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_sample_tg_sample", 32'(tg_sample), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_result", 32'(result), 32'd0);
    check("rst_mid_tg", 32'({tg_dump, tg_sample, tg_ctrl}), 32'd0);
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    run_conv(lat);
    check("post_rst_latency", 32'(lat), 32'(EXP_LAT));
    check("post_rst_result", 32'(result), 32'(5'b10110));
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
